// File: rtl/sprite_line_engine_if.sv
// ---------------------------------------------------------------------------
// sprite_line_engine_if
//  Groups the per-line control strobes, the slot load bus and the pixel
//  result bus of the sprite line engine.
//  master : the sprite fetch / pixel pipeline controller (drives loads and
//           strobes, observes the pixel results)
//  slave  : the sprite line engine itself
//  Signals
//   line_start  pulse: invalidate all slots
//   ld_en       pulse: load slot ld_slot with the ld_* fields
//   ld_slot     target slot index (values >= N_SLOTS ignored)
//   ld_x        sprite X position
//   ld_pat_lo   pattern plane 0, MSB = leftmost pixel
//   ld_pat_hi   pattern plane 1
//   ld_pal      palette select
//   ld_flip_h   mirror the pattern horizontally on capture
//   ld_behind   sprite sits behind the background
//   ld_sprite0  slot holds OAM sprite 0
//   pixel_en    one visible-pixel strobe
//   pix_color   {pal, hi, lo} of the winning slot, 0 if none opaque
//   pix_opaque  winning slot pixel non-zero
//   pix_behind  behind-BG bit of the winner, 0 if none
//   pix_sprite0 sprite-0 slot opaque this pixel
// ---------------------------------------------------------------------------
interface sprite_line_engine_if #(
   parameter int N_SLOTS = 8,
   parameter int X_W     = 8,
   parameter int PAT_W   = 8,
   parameter int PAL_W   = 2
);
   localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

   logic                line_start;
   logic                ld_en;
   logic [SLOT_W-1:0]   ld_slot;
   logic [X_W-1:0]      ld_x;
   logic [PAT_W-1:0]    ld_pat_lo;
   logic [PAT_W-1:0]    ld_pat_hi;
   logic [PAL_W-1:0]    ld_pal;
   logic                ld_flip_h;
   logic                ld_behind;
   logic                ld_sprite0;
   logic                pixel_en;
   logic [PAL_W+1:0]    pix_color;
   logic                pix_opaque;
   logic                pix_behind;
   logic                pix_sprite0;

   modport master (
      output line_start, ld_en, ld_slot, ld_x, ld_pat_lo, ld_pat_hi,
             ld_pal, ld_flip_h, ld_behind, ld_sprite0, pixel_en,
      input  pix_color, pix_opaque, pix_behind, pix_sprite0
   );

   modport slave (
      input  line_start, ld_en, ld_slot, ld_x, ld_pat_lo, ld_pat_hi,
             ld_pal, ld_flip_h, ld_behind, ld_sprite0, pixel_en,
      output pix_color, pix_opaque, pix_behind, pix_sprite0
   );
endinterface

// File: rtl/sprite_line_engine.sv
// ---------------------------------------------------------------------------
// sprite_line_engine
//  Per-scanline sprite renderer. N_SLOTS independent sprite shifters are
//  loaded during sprite fetch and then shifted one pixel per pixel_en during
//  visible rendering. Each slot counts down its X position before emitting
//  its pattern MSB-first. A fixed-priority mux picks the lowest-index opaque
//  slot; the result is registered and held between pixel strobes.
//  Ports
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    sprite_line_engine_if.slave (load bus, strobes, pixel results)
// ---------------------------------------------------------------------------
module sprite_line_engine #(
   parameter int N_SLOTS = 8,
   parameter int X_W     = 8,
   parameter int PAT_W   = 8,
   parameter int PAL_W   = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   sprite_line_engine_if.slave  bus
);

   localparam int REM_W = $clog2(PAT_W + 1);
   localparam int COL_W = PAL_W + 2;

   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]       state_q   [N_SLOTS];
   logic [1:0]       state_d   [N_SLOTS];
   logic [X_W-1:0]   x_cnt_q   [N_SLOTS];
   logic [X_W-1:0]   x_cnt_d   [N_SLOTS];
   logic [PAT_W-1:0] pat_lo_q  [N_SLOTS];
   logic [PAT_W-1:0] pat_lo_d  [N_SLOTS];
   logic [PAT_W-1:0] pat_hi_q  [N_SLOTS];
   logic [PAT_W-1:0] pat_hi_d  [N_SLOTS];
   logic [REM_W-1:0] rem_q     [N_SLOTS];
   logic [REM_W-1:0] rem_d     [N_SLOTS];
   logic [PAL_W-1:0] pal_q     [N_SLOTS];
   logic [PAL_W-1:0] pal_d     [N_SLOTS];
   logic             behind_q  [N_SLOTS];
   logic             behind_d  [N_SLOTS];
   logic             sprite0_q [N_SLOTS];
   logic             sprite0_d [N_SLOTS];

   logic [COL_W-1:0] pix_color_q, pix_color_d;
   logic             pix_opaque_q, pix_opaque_d;
   logic             pix_behind_q, pix_behind_d;
   logic             pix_sprite0_q, pix_sprite0_d;

   logic [1:0]       slot_px [N_SLOTS];
   logic             win_found;
   logic [COL_W-1:0] win_color;
   logic             win_behind;
   logic             s0_hit;

   function automatic logic [PAT_W-1:0] reverse_bits(input logic [PAT_W-1:0] v);
      logic [PAT_W-1:0] r;
      for (int b = 0; b < PAT_W; b++) begin
         r[b] = v[PAT_W-1-b];
      end
      return r;
   endfunction

   // A slot emits its pattern MSB pair while ACTIVE, or on the pixel where
   // its X countdown has reached zero (that pixel is its first drawn one).
   always_comb begin
      for (int i = 0; i < N_SLOTS; i++) begin
         slot_px[i] = 2'b00;
         if (state_q[i] == ST_ACTIVE ||
             (state_q[i] == ST_WAIT && x_cnt_q[i] == '0)) begin
            slot_px[i] = {pat_hi_q[i][PAT_W-1], pat_lo_q[i][PAT_W-1]};
         end
      end
   end

   // Lowest-index opaque slot wins; sprite-0 hit is tracked separately so it
   // is reported even when a higher-priority slot covers it.
   always_comb begin
      win_found  = 1'b0;
      win_color  = '0;
      win_behind = 1'b0;
      s0_hit     = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (!win_found && slot_px[i] != 2'b00) begin
            win_found  = 1'b1;
            win_color  = {pal_q[i], slot_px[i]};
            win_behind = behind_q[i];
         end
         if (sprite0_q[i] && slot_px[i] != 2'b00) begin
            s0_hit = 1'b1;
         end
      end
   end

   // Slot update order matters: pixel advance first, then line_start clears
   // everything, then a load overrides its own slot. This gives load
   // priority over both the shift and the clear for the targeted slot.
   always_comb begin
      for (int i = 0; i < N_SLOTS; i++) begin
         state_d[i]   = state_q[i];
         x_cnt_d[i]   = x_cnt_q[i];
         pat_lo_d[i]  = pat_lo_q[i];
         pat_hi_d[i]  = pat_hi_q[i];
         rem_d[i]     = rem_q[i];
         pal_d[i]     = pal_q[i];
         behind_d[i]  = behind_q[i];
         sprite0_d[i] = sprite0_q[i];

         if (bus.pixel_en) begin
            case (state_q[i])
               ST_WAIT: begin
                  if (x_cnt_q[i] != '0) begin
                     x_cnt_d[i] = x_cnt_q[i] - X_W'(1);
                  end else begin
                     pat_lo_d[i] = pat_lo_q[i] << 1;
                     pat_hi_d[i] = pat_hi_q[i] << 1;
                     rem_d[i]    = REM_W'(PAT_W - 1);
                     state_d[i]  = (PAT_W == 1) ? ST_DONE : ST_ACTIVE;
                  end
               end
               ST_ACTIVE: begin
                  pat_lo_d[i] = pat_lo_q[i] << 1;
                  pat_hi_d[i] = pat_hi_q[i] << 1;
                  rem_d[i]    = rem_q[i] - REM_W'(1);
                  if (rem_q[i] == REM_W'(1)) begin
                     state_d[i] = ST_DONE;
                  end
               end
               default: begin
               end
            endcase
         end

         if (bus.line_start) begin
            state_d[i] = ST_EMPTY;
         end

         if (bus.ld_en && int'(bus.ld_slot) == i) begin
            state_d[i]   = ST_WAIT;
            x_cnt_d[i]   = bus.ld_x;
            pat_lo_d[i]  = bus.ld_flip_h ? reverse_bits(bus.ld_pat_lo) : bus.ld_pat_lo;
            pat_hi_d[i]  = bus.ld_flip_h ? reverse_bits(bus.ld_pat_hi) : bus.ld_pat_hi;
            rem_d[i]     = '0;
            pal_d[i]     = bus.ld_pal;
            behind_d[i]  = bus.ld_behind;
            sprite0_d[i] = bus.ld_sprite0;
         end
      end
   end

   // Pixel results are captured only on pixel_en and held otherwise; a
   // coincident line_start blanks the captured pixel.
   always_comb begin
      pix_color_d   = pix_color_q;
      pix_opaque_d  = pix_opaque_q;
      pix_behind_d  = pix_behind_q;
      pix_sprite0_d = pix_sprite0_q;
      if (bus.pixel_en) begin
         if (bus.line_start) begin
            pix_color_d   = '0;
            pix_opaque_d  = 1'b0;
            pix_behind_d  = 1'b0;
            pix_sprite0_d = 1'b0;
         end else begin
            pix_color_d   = win_color;
            pix_opaque_d  = win_found;
            pix_behind_d  = win_behind;
            pix_sprite0_d = s0_hit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            state_q[i]   <= ST_EMPTY;
            x_cnt_q[i]   <= '0;
            pat_lo_q[i]  <= '0;
            pat_hi_q[i]  <= '0;
            rem_q[i]     <= '0;
            pal_q[i]     <= '0;
            behind_q[i]  <= 1'b0;
            sprite0_q[i] <= 1'b0;
         end
         pix_color_q   <= '0;
         pix_opaque_q  <= 1'b0;
         pix_behind_q  <= 1'b0;
         pix_sprite0_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_SLOTS; i++) begin
            state_q[i]   <= state_d[i];
            x_cnt_q[i]   <= x_cnt_d[i];
            pat_lo_q[i]  <= pat_lo_d[i];
            pat_hi_q[i]  <= pat_hi_d[i];
            rem_q[i]     <= rem_d[i];
            pal_q[i]     <= pal_d[i];
            behind_q[i]  <= behind_d[i];
            sprite0_q[i] <= sprite0_d[i];
         end
         pix_color_q   <= pix_color_d;
         pix_opaque_q  <= pix_opaque_d;
         pix_behind_q  <= pix_behind_d;
         pix_sprite0_q <= pix_sprite0_d;
      end
   end

   assign bus.pix_color   = pix_color_q;
   assign bus.pix_opaque  = pix_opaque_q;
   assign bus.pix_behind  = pix_behind_q;
   assign bus.pix_sprite0 = pix_sprite0_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// ---------------------------------------------------------------------------
// tb_sprite_line_engine
//  Directed bench for sprite_line_engine with default parameters
//  (8 slots, 8-bit X, 8-pixel patterns, 2-bit palette).
// ---------------------------------------------------------------------------
module tb_sprite_line_engine;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   sprite_line_engine_if #(.N_SLOTS(8), .X_W(8), .PAT_W(8), .PAL_W(2)) bus ();

   sprite_line_engine #(.N_SLOTS(8), .X_W(8), .PAT_W(8), .PAL_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 100 MHz-style free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after the rising edge, away from sampling.
   task automatic idle_inputs();
      bus.line_start = 1'b0;
      bus.ld_en      = 1'b0;
      bus.ld_slot    = '0;
      bus.ld_x       = '0;
      bus.ld_pat_lo  = '0;
      bus.ld_pat_hi  = '0;
      bus.ld_pal     = '0;
      bus.ld_flip_h  = 1'b0;
      bus.ld_behind  = 1'b0;
      bus.ld_sprite0 = 1'b0;
      bus.pixel_en   = 1'b0;
   endtask

   task automatic set_load(input logic [2:0] slot, input logic [7:0] x,
                           input logic [7:0] lo, input logic [7:0] hi,
                           input logic [1:0] pal, input logic flip,
                           input logic behind, input logic s0);
      bus.ld_en      = 1'b1;
      bus.ld_slot    = slot;
      bus.ld_x       = x;
      bus.ld_pat_lo  = lo;
      bus.ld_pat_hi  = hi;
      bus.ld_pal     = pal;
      bus.ld_flip_h  = flip;
      bus.ld_behind  = behind;
      bus.ld_sprite0 = s0;
   endtask

   task automatic load_slot(input logic [2:0] slot, input logic [7:0] x,
                            input logic [7:0] lo, input logic [7:0] hi,
                            input logic [1:0] pal, input logic flip,
                            input logic behind, input logic s0);
      set_load(slot, x, lo, hi, pal, flip, behind, s0);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic new_line();
      bus.line_start = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic step_pixel();
      bus.pixel_en = 1'b1;
      @(posedge clk);
      #1;
      bus.pixel_en = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (bus.pix_color !== 4'h0 || bus.pix_opaque !== 1'b0 ||
          bus.pix_behind !== 1'b0 || bus.pix_sprite0 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs got color=%h op=%b bh=%b s0=%b want all 0",
                  bus.pix_color, bus.pix_opaque, bus.pix_behind, bus.pix_sprite0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      load_slot(3'd0, 8'd0, 8'hFF, 8'hFF, 2'd1, 1'b0, 1'b1, 1'b1);
      step_pixel();
      n_tests++;
      if (bus.pix_opaque !== 1'b1 || bus.pix_color !== 4'b0111) begin
         n_fail++;
         $display("[TB] FAIL reset_prerender got op=%b color=%b want 1 0111",
                  bus.pix_opaque, bus.pix_color);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.pix_color !== 4'h0 || bus.pix_opaque !== 1'b0 ||
          bus.pix_behind !== 1'b0 || bus.pix_sprite0 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_async got color=%h op=%b bh=%b s0=%b want all 0",
                  bus.pix_color, bus.pix_opaque, bus.pix_behind, bus.pix_sprite0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step_pixel();
         n_tests++;
         if (bus.pix_opaque !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_after px%0d opaque got %b want 0", k, bus.pix_opaque);
         end
      end
   endtask

   task automatic test_basic();
      logic [3:0] exp_col;
      new_line();
      load_slot(3'd0, 8'd3, 8'hFF, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         step_pixel();
         exp_col = (k >= 3 && k <= 10) ? 4'b1001 : 4'b0000;
         n_tests++;
         if (bus.pix_color !== exp_col) begin
            n_fail++;
            $display("[TB] FAIL basic px%0d color got %b want %b", k, bus.pix_color, exp_col);
         end
      end
   endtask

   task automatic test_flip();
      logic exp_op;
      for (int f = 0; f < 2; f++) begin
         new_line();
         load_slot(3'd0, 8'd0, 8'h80, 8'h00, 2'd0, (f == 0), 1'b0, 1'b0);
         for (int k = 0; k < 10; k++) begin
            step_pixel();
            exp_op = (f == 0) ? (k == 7) : (k == 0);
            n_tests++;
            if (bus.pix_opaque !== exp_op) begin
               n_fail++;
               $display("[TB] FAIL flip%0d px%0d opaque got %b want %b",
                        1 - f, k, bus.pix_opaque, exp_op);
            end
         end
      end
   endtask

   task automatic test_priority();
      logic [3:0] exp_col;
      logic       exp_bh;
      new_line();
      load_slot(3'd1, 8'd0, 8'hFF, 8'hFF, 2'd1, 1'b0, 1'b1, 1'b0);
      load_slot(3'd0, 8'd0, 8'h0F, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         step_pixel();
         if (k < 4) begin
            exp_col = 4'b0111;
            exp_bh  = 1'b1;
         end else if (k < 8) begin
            exp_col = 4'b1101;
            exp_bh  = 1'b0;
         end else begin
            exp_col = 4'b0000;
            exp_bh  = 1'b0;
         end
         n_tests++;
         if (bus.pix_color !== exp_col || bus.pix_behind !== exp_bh) begin
            n_fail++;
            $display("[TB] FAIL priority px%0d got color=%b bh=%b want %b %b",
                     k, bus.pix_color, bus.pix_behind, exp_col, exp_bh);
         end
      end
   endtask

   task automatic test_sprite0();
      logic [3:0] exp_col;
      logic       exp_s0;
      new_line();
      load_slot(3'd0, 8'd0, 8'hFF, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
      load_slot(3'd2, 8'd2, 8'hFF, 8'h00, 2'd3, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         step_pixel();
         exp_s0  = (k >= 2 && k <= 9);
         exp_col = (k < 8) ? 4'b0001 : ((k <= 9) ? 4'b1101 : 4'b0000);
         n_tests++;
         if (bus.pix_sprite0 !== exp_s0 || bus.pix_color !== exp_col) begin
            n_fail++;
            $display("[TB] FAIL sprite0 px%0d got s0=%b color=%b want %b %b",
                     k, bus.pix_sprite0, bus.pix_color, exp_s0, exp_col);
         end
      end
   endtask

   task automatic test_edges();
      logic [3:0] exp_col;
      int         bad;
      new_line();
      load_slot(3'd0, 8'd255, 8'h80, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
      bad = 0;
      for (int k = 0; k < 262; k++) begin
         step_pixel();
         if (bus.pix_opaque !== (k == 255)) begin
            bad++;
            if (bad < 4) begin
               $display("[TB] FAIL edge_x255 px%0d opaque got %b want %b",
                        k, bus.pix_opaque, (k == 255));
            end
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("[TB] FAIL edge_x255 summary got %0d bad pixels want 0", bad);
      end

      // Slot 1 waits at x=0; the coincident line_start must drop it while the
      // simultaneous load into slot 3 survives.
      new_line();
      load_slot(3'd1, 8'd0, 8'hFF, 8'hFF, 2'd2, 1'b0, 1'b0, 1'b0);
      bus.line_start = 1'b1;
      set_load(3'd3, 8'd1, 8'hFF, 8'hFF, 2'd1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      idle_inputs();
      for (int k = 0; k < 10; k++) begin
         step_pixel();
         exp_col = (k >= 1 && k <= 8) ? 4'b0111 : 4'b0000;
         n_tests++;
         if (bus.pix_color !== exp_col) begin
            n_fail++;
            $display("[TB] FAIL ls_load px%0d color got %b want %b", k, bus.pix_color, exp_col);
         end
      end

      // line_start together with pixel_en blanks the pixel even while a slot
      // would have been opaque.
      new_line();
      load_slot(3'd0, 8'd0, 8'hFF, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
      bus.line_start = 1'b1;
      bus.pixel_en   = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      n_tests++;
      if (bus.pix_opaque !== 1'b0 || bus.pix_color !== 4'h0) begin
         n_fail++;
         $display("[TB] FAIL ls_pixel got op=%b color=%b want 0 0000",
                  bus.pix_opaque, bus.pix_color);
      end
      step_pixel();
      n_tests++;
      if (bus.pix_opaque !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL ls_pixel_next opaque got %b want 0", bus.pix_opaque);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      idle_inputs();
      test_reset();
      test_basic();
      test_flip();
      test_priority();
      test_sprite0();
      test_edges();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
